// File: rtl/smc_cfg_pkg.sv
// ---------------------------------------------------------------------------------------------
// smc_cfg_pkg
//   Shared definitions for the SMC static config reader:
//     - state_e      : reader FSM encoding (IDLE=0, SEL_A=1, SEL_B=2, CHECK=3)
//     - field bounds : MSB/LSB of the mode / rsvd / timing / width fields inside the config word
//     - CntW         : width of the settle and retry counters
// ---------------------------------------------------------------------------------------------
package smc_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSelA  = 2'd1,
        StSelB  = 2'd2,
        StCheck = 2'd3
    } state_e;

    localparam int unsigned CfgW = 32;
    localparam int unsigned CntW = 4;

    localparam int unsigned ModeMsb   = 31;
    localparam int unsigned ModeLsb   = 30;
    localparam int unsigned RsvdMsb   = 29;
    localparam int unsigned RsvdLsb   = 22;
    localparam int unsigned TimingMsb = 21;
    localparam int unsigned TimingLsb = 8;
    localparam int unsigned WidthMsb  = 7;
    localparam int unsigned WidthLsb  = 0;

    localparam int unsigned ModeW   = ModeMsb - ModeLsb + 1;
    localparam int unsigned RsvdW   = RsvdMsb - RsvdLsb + 1;
    localparam int unsigned TimingW = TimingMsb - TimingLsb + 1;
    localparam int unsigned WidthW  = WidthMsb - WidthLsb + 1;

    // Timing field holds seven 2-bit sub-fields, field0 in the lowest bits.
    localparam int unsigned TimingFieldW = 2;
    localparam int unsigned TimingFields = TimingW / TimingFieldW;

endpackage

// File: rtl/smc_cfg_reader_decode.sv
// ---------------------------------------------------------------------------------------------
// smc_cfg_decode
//   Pure combinational slicing of the confirmed config word into its fields.
//   Ports:
//     cfg_word_i   in  32  confirmed config word
//     mode_o       out  2  cfg_word[31:30]
//     rsvd_o       out  8  cfg_word[29:22]
//     timing_o     out 14  cfg_word[21:8], seven 2-bit timing fields, field0 at [1:0]
//     width_o      out  8  cfg_word[7:0]
// ---------------------------------------------------------------------------------------------
module smc_cfg_decode
    import smc_cfg_pkg::*;
(
    input  logic [CfgW-1:0]    cfg_word_i,
    output logic [ModeW-1:0]   mode_o,
    output logic [RsvdW-1:0]   rsvd_o,
    output logic [TimingW-1:0] timing_o,
    output logic [WidthW-1:0]  width_o
);

    always_comb begin
        mode_o   = cfg_word_i[ModeMsb:ModeLsb];
        rsvd_o   = cfg_word_i[RsvdMsb:RsvdLsb];
        timing_o = cfg_word_i[TimingMsb:TimingLsb];
        width_o  = cfg_word_i[WidthMsb:WidthLsb];
    end

endmodule

// File: rtl/smc_cfg_reader.sv
// ---------------------------------------------------------------------------------------------
// smc_cfg_reader
//   Read-side master for the SMC static config register. On a load request it raises cfg_sel,
//   lets the read data settle for SEL_CYCLES, takes two samples and accepts the word only when
//   both samples agree. Disagreeing pairs are retried up to MAX_RETRY times before cfg_err.
//   The confirmed word is held in cfg_word and sliced into fields for the SMC state machines.
//
//   Parameters:
//     SEL_CYCLES  settle cycles before each sample (1..15)
//     MAX_RETRY   mismatching sample pairs tolerated before error (1..15)
//
//   Ports:
//     hclk         in   1   system clock, rising edge
//     n_sys_reset  in   1   asynchronous active-low reset
//     start        in   1   load request pulse, ignored while busy
//     cfg_sel      out  1   register select to the config register
//     cfg_rdata    in  32   config register read data
//     busy         out  1   load in progress
//     cfg_valid    out  1   cfg_word holds a confirmed word
//     cfg_err      out  1   MAX_RETRY mismatches seen, sticky until next accepted start
//     cfg_word     out 32   last confirmed config word
//     cfg_mode     out  2   cfg_word[31:30]
//     cfg_rsvd     out  8   cfg_word[29:22]
//     cfg_timing   out 14   cfg_word[21:8]
//     cfg_width    out  8   cfg_word[7:0]
//
//   Build option:
//     SMC_CFG_AUTOLOAD_EN  when defined, one internal start is issued in the first cycle after
//                          reset release so cfg_valid comes up without an external start.
//
//   Timing: a start accepted at edge N is held for one cycle in load_q, the FSM enters SEL_A at
//   N+1 and cfg_valid rises at N+2*SEL_CYCLES+2 when both samples agree.
// ---------------------------------------------------------------------------------------------
module smc_cfg_reader
    import smc_cfg_pkg::*;
#(
    parameter int unsigned SEL_CYCLES = 2,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic               hclk,
    input  logic               n_sys_reset,
    input  logic               start,
    output logic               cfg_sel,
    input  logic [CfgW-1:0]    cfg_rdata,
    output logic               busy,
    output logic               cfg_valid,
    output logic               cfg_err,
    output logic [CfgW-1:0]    cfg_word,
    output logic [ModeW-1:0]   cfg_mode,
    output logic [RsvdW-1:0]   cfg_rsvd,
    output logic [TimingW-1:0] cfg_timing,
    output logic [WidthW-1:0]  cfg_width
);

    localparam logic [CntW-1:0] LastSettle = CntW'(SEL_CYCLES - 1);
    localparam logic [CntW-1:0] RetryLimit = CntW'(MAX_RETRY);

    state_e            state_q;
    logic [CntW-1:0]   settle_q;
    logic [CntW-1:0]   retry_q;
    logic [CntW-1:0]   retry_inc;
    logic [CfgW-1:0]   sample_a_q;
    logic [CfgW-1:0]   sample_b_q;
    logic              load_q;
    logic              start_req;
    logic              accept;
    logic              settle_done;

    // -----------------------------------------------------------------------------------------
    // Load request source
    // -----------------------------------------------------------------------------------------
`ifdef SMC_CFG_AUTOLOAD_EN
    // boot_q stays low for exactly the first cycle after reset release, giving one internal
    // start pulse; it is set on the first edge and never cleared again until the next reset.
    logic boot_q;

    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            boot_q <= 1'b0;
        end else begin
            boot_q <= 1'b1;
        end
    end

    assign start_req = start | ~boot_q;
`else
    assign start_req = start;
`endif

    // busy covers the whole load from acceptance to CHECK exit, so a start arriving in the
    // CHECK cycle itself is dropped rather than chaining a second load.
    assign accept      = start_req & ~busy & (state_q == StIdle);
    assign settle_done = (settle_q == LastSettle);
    assign retry_inc   = retry_q + CntW'(1);

    // -----------------------------------------------------------------------------------------
    // Reader FSM with registered outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            retry_q    <= '0;
            sample_a_q <= '0;
            sample_b_q <= '0;
            load_q     <= 1'b0;
            cfg_sel    <= 1'b0;
            busy       <= 1'b0;
            cfg_valid  <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_word   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_q) begin
                        // Launch cycle: request was accepted on the previous edge.
                        load_q   <= 1'b0;
                        settle_q <= '0;
                        cfg_sel  <= 1'b1;
                        state_q  <= StSelA;
                    end else if (accept) begin
                        load_q    <= 1'b1;
                        busy      <= 1'b1;
                        cfg_valid <= 1'b0;
                        cfg_err   <= 1'b0;
                        retry_q   <= '0;
                    end
                end

                StSelA: begin
                    if (settle_done) begin
                        sample_a_q <= cfg_rdata;
                        settle_q   <= '0;
                        state_q    <= StSelB;
                    end else begin
                        settle_q <= settle_q + CntW'(1);
                    end
                end

                StSelB: begin
                    if (settle_done) begin
                        sample_b_q <= cfg_rdata;
                        settle_q   <= '0;
                        cfg_sel    <= 1'b0;
                        state_q    <= StCheck;
                    end else begin
                        settle_q <= settle_q + CntW'(1);
                    end
                end

                StCheck: begin
                    if (sample_a_q == sample_b_q) begin
                        cfg_word  <= sample_a_q;
                        cfg_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        retry_q <= retry_inc;
                        if (retry_inc == RetryLimit) begin
                            // Give up; the previously confirmed word stays in cfg_word.
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            cfg_sel <= 1'b1;
                            state_q <= StSelA;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cfg_sel <= 1'b0;
                    busy    <= 1'b0;
                    load_q  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Field decode
    // -----------------------------------------------------------------------------------------
    smc_cfg_decode u_decode (
        .cfg_word_i (cfg_word),
        .mode_o     (cfg_mode),
        .rsvd_o     (cfg_rsvd),
        .timing_o   (cfg_timing),
        .width_o    (cfg_width)
    );

endmodule

// File: tb/tb_smc_cfg_reader.sv
// ---------------------------------------------------------------------------------------------
// tb_smc_cfg_reader
//   Directed bench for smc_cfg_reader with SEL_CYCLES=2, MAX_RETRY=3. Inputs are driven and
//   outputs sampled 1ns after the rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------------------------
module tb_smc_cfg_reader;

`ifdef SMC_CFG_AUTOLOAD_EN
    localparam bit Auto = 1'b1;
`else
    localparam bit Auto = 1'b0;
`endif

    // Hand-decoded test words.
    localparam logic [31:0] W1 = 32'hC000_0001;  // mode 3, rsvd 00, timing 0000, width 01
    localparam logic [31:0] W2 = 32'h5A3C_96A5;  // mode 1, rsvd 68, timing 3C96, width A5
    localparam logic [31:0] W4 = 32'h8123_4567;  // mode 2, width 67
    localparam logic [31:0] W5 = 32'h0F0F_3C5A;

    logic        hclk;
    logic        n_sys_reset;
    logic        start;
    logic        cfg_sel;
    logic [31:0] cfg_rdata;
    logic        busy;
    logic        cfg_valid;
    logic        cfg_err;
    logic [31:0] cfg_word;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_rsvd;
    logic [13:0] cfg_timing;
    logic [7:0]  cfg_width;

    int n_checks = 0;
    int n_bad    = 0;

    smc_cfg_reader #(
        .SEL_CYCLES (2),
        .MAX_RETRY  (3)
    ) dut (
        .hclk        (hclk),
        .n_sys_reset (n_sys_reset),
        .start       (start),
        .cfg_sel     (cfg_sel),
        .cfg_rdata   (cfg_rdata),
        .busy        (busy),
        .cfg_valid   (cfg_valid),
        .cfg_err     (cfg_err),
        .cfg_word    (cfg_word),
        .cfg_mode    (cfg_mode),
        .cfg_rsvd    (cfg_rsvd),
        .cfg_timing  (cfg_timing),
        .cfg_width   (cfg_width)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Start is sampled on the next edge (edge N); returns 1ns after edge N.
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        start       = 1'b0;
        cfg_rdata   = W1;
        n_sys_reset = 1'b0;
        #12;
        check("rst_sel",   32'(cfg_sel),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_err",   32'(cfg_err),   32'd0);
        check("rst_word",  cfg_word,       32'd0);

        // Reset release mid-cycle; next edge is edge 1.
        n_sys_reset = 1'b1;
        tick(6);
        check("boot_valid_e6", 32'(cfg_valid), 32'd0);
        tick(1);
        check("boot_valid_e7", 32'(cfg_valid), 32'(Auto));
        tick(2);
        check("boot_idle", 32'(busy), 32'd0);

        // Clean load, plus a start held during the CHECK cycle that must be dropped.
        cfg_rdata = W1;
        pulse_start();
        check("t1_busy_n",  32'(busy),      32'd1);
        check("t1_sel_n",   32'(cfg_sel),   32'd0);
        check("t1_valid_n", 32'(cfg_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check($sformatf("t1_sel_hi_%0d", i), 32'(cfg_sel), 32'd1);
        end
        tick(1);
        check("t1_sel_chk",   32'(cfg_sel),   32'd0);
        check("t1_valid_n5",  32'(cfg_valid), 32'd0);
        check("t1_busy_n5",   32'(busy),      32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t1_valid_n6",  32'(cfg_valid), 32'd1);
        check("t1_busy_n6",   32'(busy),      32'd0);
        check("t1_word",      cfg_word,       W1);
        check("t1_mode",      32'(cfg_mode),  32'h3);
        check("t1_width",     32'(cfg_width), 32'h01);
        check("t1_timing",    32'(cfg_timing), 32'h0);
        check("t1_rsvd",      32'(cfg_rsvd),  32'h0);
        tick(1);
        check("t1_exit_start_busy", 32'(busy),    32'd0);
        check("t1_exit_start_sel",  32'(cfg_sel), 32'd0);
        tick(2);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // One glitched sample pair, then stable: one retry costs 5 cycles.
        cfg_rdata = W2;
        pulse_start();
        tick(3);
        cfg_rdata = W2 ^ 32'h0000_0100;
        tick(2);
        cfg_rdata = W2;
        check("t2_sel_chk",  32'(cfg_sel), 32'd0);
        check("t2_busy_chk", 32'(busy),    32'd1);
        tick(1);
        check("t2_valid_n6", 32'(cfg_valid), 32'd0);
        check("t2_sel_retry", 32'(cfg_sel),  32'd1);
        check("t2_err_n6",   32'(cfg_err),   32'd0);
        tick(4);
        check("t2_valid_n10", 32'(cfg_valid), 32'd0);
        tick(1);
        check("t2_valid_n11", 32'(cfg_valid), 32'd1);
        check("t2_err",       32'(cfg_err),   32'd0);
        check("t2_busy",      32'(busy),      32'd0);
        check("t2_word",      cfg_word,       W2);
        check("t2_mode",      32'(cfg_mode),  32'h1);
        check("t2_rsvd",      32'(cfg_rsvd),  32'h68);
        check("t2_timing",    32'(cfg_timing), 32'h3C96);
        check("t2_width",     32'(cfg_width), 32'hA5);
        tick(2);

        // Data changes every cycle: three failing CHECKs, error at N+16, word kept.
        pulse_start();
        check("t3_valid_clr", 32'(cfg_valid), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cfg_rdata = 32'h1234_0000 + 32'(i);
            tick(1);
        end
        check("t3_err_n15",  32'(cfg_err), 32'd0);
        check("t3_busy_n15", 32'(busy),    32'd1);
        tick(1);
        check("t3_err",   32'(cfg_err),   32'd1);
        check("t3_valid", 32'(cfg_valid), 32'd0);
        check("t3_busy",  32'(busy),      32'd0);
        check("t3_sel",   32'(cfg_sel),   32'd0);
        check("t3_word",  cfg_word,       W2);
        tick(3);
        check("t3_err_sticky", 32'(cfg_err), 32'd1);

        // Start during SEL_B is ignored; latency unchanged.
        cfg_rdata = W4;
        pulse_start();
        check("t4_err_clr", 32'(cfg_err), 32'd0);
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("t4_valid_n5", 32'(cfg_valid), 32'd0);
        tick(1);
        check("t4_valid_n6", 32'(cfg_valid), 32'd1);
        check("t4_busy_n6",  32'(busy),      32'd0);
        check("t4_word",     cfg_word,       W4);
        check("t4_mode",     32'(cfg_mode),  32'h2);
        check("t4_width",    32'(cfg_width), 32'h67);
        tick(3);
        check("t4_no_requeue_busy", 32'(busy),    32'd0);
        check("t4_no_requeue_sel",  32'(cfg_sel), 32'd0);

        // Reset in SEL_A clears everything at once; next load is clean.
        pulse_start();
        tick(1);
        check("t5_sel_pre", 32'(cfg_sel), 32'd1);
        n_sys_reset = 1'b0;
        #1;
        check("t5_sel_rst",   32'(cfg_sel),   32'd0);
        check("t5_busy_rst",  32'(busy),      32'd0);
        check("t5_valid_rst", 32'(cfg_valid), 32'd0);
        check("t5_word_rst",  cfg_word,       32'd0);
        #3;
        n_sys_reset = 1'b1;
        tick(8);
        cfg_rdata = W5;
        pulse_start();
        tick(5);
        check("t5_valid_n5", 32'(cfg_valid), 32'd0);
        tick(1);
        check("t5_valid_n6", 32'(cfg_valid), 32'd1);
        check("t5_word",     cfg_word,       W5);
        check("t5_err",      32'(cfg_err),   32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
